// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared defaults and register typedefs for the integer register file.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int          RF_DATA_W = 32;
  localparam int          RF_ADDR_W = 5;
  localparam int          RF_SP_IDX = 2;
  localparam logic [31:0] RF_SP_RST = 32'h7fffefe4;

  typedef logic [RF_ADDR_W-1:0] regaddr_t;
  typedef logic [RF_DATA_W-1:0] regdata_t;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Per-register busy bits with issue/writeback/flush update and
//            NRD busy lookups. Macro RF_BYPASS_EN enables same-cycle busy bypass.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  iss_v,
  input  logic [ADDR_W-1:0]     iss_rd,
  input  logic                  we_a,
  input  logic [ADDR_W-1:0]     wa_a,
  input  logic                  we_b,
  input  logic [ADDR_W-1:0]     wa_b,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD-1:0]        busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_clr;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (iss_v) w_set[iss_rd] = 1'b1;
    if (we_a)  w_clr[wa_a]   = 1'b1;
    if (we_b)  w_clr[wa_b]   = 1'b1;
    if (ZERO_REG) w_set[0] = 1'b0;
  end

  // Set is OR-ed after the clear so a newly issued producer beats its own writeback.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_lookup
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = ra[i*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
    logic w_wr_hit;
    assign w_wr_hit = ((we_a && (wa_a == w_addr)) || (we_b && (wa_b == w_addr)))
                      && !(ZERO_REG && (w_addr == '0));
    assign busy[i]  = w_wr_hit ? w_set[w_addr] : r_busy[w_addr];
`else
    assign busy[i]  = r_busy[w_addr];
`endif
  end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-port register file, NRD async reads, two prioritised write
//            ports and busy scoreboard. Macro RF_BYPASS_EN adds write-to-read bypass.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int          DATA_W   = RF_DATA_W,
  parameter int          ADDR_W   = RF_ADDR_W,
  parameter int          NRD      = 2,
  parameter int          SP_IDX   = RF_SP_IDX,
  parameter logic [31:0] SP_RST   = RF_SP_RST,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_a,
  input  logic [ADDR_W-1:0]     wa_a,
  input  logic [DATA_W-1:0]     wd_a,
  input  logic                  we_b,
  input  logic [ADDR_W-1:0]     wa_b,
  input  logic [DATA_W-1:0]     wd_b,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        busy,
  input  logic                  iss_v,
  input  logic [ADDR_W-1:0]     iss_rd,
  input  logic                  flush
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_we_a;
  logic              w_we_b;

  assign w_we_a = we_a && !(ZERO_REG && (wa_a == '0));
  assign w_we_b = we_b && !(ZERO_REG && (wa_b == '0));

  // Port B is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= (i == SP_IDX) ? DATA_W'(SP_RST) : '0;
      end
    end else begin
      if (w_we_a) r_mem[wa_a] <= wd_a;
      if (w_we_b) r_mem[wa_b] <= wd_b;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_read
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_stored;
    logic [DATA_W-1:0] w_data;
    assign w_addr   = ra[i*ADDR_W +: ADDR_W];
    assign w_stored = (ZERO_REG && (w_addr == '0)) ? '0 : r_mem[w_addr];
`ifdef RF_BYPASS_EN
    assign w_data   = (w_we_b && (wa_b == w_addr)) ? wd_b :
                      (w_we_a && (wa_a == w_addr)) ? wd_a : w_stored;
`else
    assign w_data   = w_stored;
`endif
    assign rd[i*DATA_W +: DATA_W] = w_data;
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .iss_v  (iss_v),
    .iss_rd (iss_rd),
    .we_a   (we_a),
    .wa_a   (wa_a),
    .we_b   (we_b),
    .wa_b   (wa_b),
    .ra     (ra),
    .busy   (busy)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Self-checking bench for regfile_mp: directed cases then random
//            traffic against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int NRD   = 2;
  localparam int AW    = RF_ADDR_W;
  localparam int DW    = RF_DATA_W;
  localparam int DEPTH = 2**AW;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, we_a, we_b, iss_v, flush;
  regaddr_t          wa_a, wa_b, iss_rd;
  regdata_t          wd_a, wd_b;
  logic [NRD*AW-1:0] ra;
  logic [NRD*DW-1:0] rd;
  logic [NRD-1:0]    busy;

  regdata_t m_mem [DEPTH];
  logic     m_bsy [DEPTH];
  bit       m_valid = 1'b0;
  int       n_chk   = 0;
  int       n_pass  = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W (DW), .ADDR_W (AW), .NRD (NRD),
    .SP_IDX (2), .SP_RST (32'h7fffefe4), .ZERO_REG (1'b1)
  ) dut (
    .clk (clk), .rst (rst),
    .we_a (we_a), .wa_a (wa_a), .wd_a (wd_a),
    .we_b (we_b), .wa_b (wa_b), .wd_b (wd_b),
    .ra (ra), .rd (rd), .busy (busy),
    .iss_v (iss_v), .iss_rd (iss_rd), .flush (flush)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic regdata_t exp_rd(input regaddr_t a);
    if (a == 0) return '0;
    if (BYP && we_b && wa_b == a) return wd_b;
    if (BYP && we_a && wa_a == a) return wd_a;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input regaddr_t a);
    if (BYP && a != 0 && ((we_a && wa_a == a) || (we_b && wa_b == a)))
      return iss_v && (iss_rd == a);
    return m_bsy[a];
  endfunction

  function automatic regdata_t get_rd(input int p);
    return rd[p*DW +: DW];
  endfunction

  task automatic set_ra(input int p, input regaddr_t a);
    ra[p*AW +: AW] = a;
  endtask

  task automatic compare_all();
    for (int i = 0; i < NRD; i++) begin
      regaddr_t a;
      a = ra[i*AW +: AW];
      check_eq($sformatf("rd%0d@r%0d", i, a), get_rd(i), exp_rd(a));
      check_eq($sformatf("busy%0d@r%0d", i, a), {31'b0, busy[i]}, {31'b0, exp_busy(a)});
    end
  endtask

  // Architectural effect of one clock edge, straight from the register-file rules.
  task automatic model_edge();
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_mem[r] = '0;
        m_bsy[r] = 1'b0;
      end
      m_mem[2] = 32'h7fffefe4;
      m_valid  = 1'b1;
    end else begin
      logic nb [DEPTH];
      for (int r = 0; r < DEPTH; r++) begin
        regaddr_t ra_r;
        ra_r = regaddr_t'(r);
        if (flush) nb[r] = 1'b0;
        else if (iss_v && iss_rd == ra_r && r != 0) nb[r] = 1'b1;
        else if ((we_a && wa_a == ra_r) || (we_b && wa_b == ra_r)) nb[r] = 1'b0;
        else nb[r] = m_bsy[r];
      end
      for (int r = 0; r < DEPTH; r++) m_bsy[r] = nb[r];
      if (we_a && wa_a != 0) m_mem[wa_a] = wd_a;
      if (we_b && wa_b != 0) m_mem[wa_b] = wd_b;
    end
  endtask

  task automatic tick();
    #1;
    if (m_valid) compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; iss_v = 1'b0; iss_rd = '0;
    we_a = 1'b0; wa_a = '0; wd_a = '0;
    we_b = 1'b0; wa_b = '0; wd_b = '0;
  endtask

  function automatic regaddr_t rnd_addr();
    if ($urandom_range(0, 3) == 0) return regaddr_t'($urandom_range(0, 3));
    return regaddr_t'($urandom_range(0, DEPTH-1));
  endfunction

  initial begin
    idle();
    ra  = '0;
    rst = 1'b1;
    tick();

    rst = 1'b0; set_ra(0, 0); set_ra(1, 2);
    #1;
    check_eq("rst_r0", get_rd(0), 32'h0);
    check_eq("rst_sp", get_rd(1), 32'h7fffefe4);
    check_eq("rst_busy", {30'b0, busy}, 32'h0);
    tick();

    we_a = 1'b1; wa_a = 5; wd_a = 32'hdeadbeef; set_ra(0, 5);
    #1;
    check_eq("wr_same_cycle", get_rd(0), BYP ? 32'hdeadbeef : 32'h0);
    tick();
    idle();
    #1;
    check_eq("wr_next_cycle", get_rd(0), 32'hdeadbeef);
    tick();

    we_a = 1'b1; wa_a = 7; wd_a = 32'h11111111;
    we_b = 1'b1; wa_b = 7; wd_b = 32'h22222222;
    tick();
    idle(); set_ra(0, 7);
    #1;
    check_eq("port_b_wins", get_rd(0), 32'h22222222);
    tick();

    we_b = 1'b1; wa_b = 0; wd_b = 32'hffffffff; iss_v = 1'b1; iss_rd = 0; set_ra(0, 0);
    tick();
    idle();
    #1;
    check_eq("zero_rd", get_rd(0), 32'h0);
    check_eq("zero_busy", {31'b0, busy[0]}, 32'h0);
    tick();

    iss_v = 1'b1; iss_rd = 9; set_ra(0, 9);
    tick();
    idle();
    #1;
    check_eq("iss_set", {31'b0, busy[0]}, 32'h1);
    we_a = 1'b1; wa_a = 9; wd_a = 32'h00000999;
    #1;
    check_eq("wb_busy_now", {31'b0, busy[0]}, BYP ? 32'h0 : 32'h1);
    tick();
    idle();
    #1;
    check_eq("wb_clear", {31'b0, busy[0]}, 32'h0);
    iss_v = 1'b1; iss_rd = 9; we_a = 1'b1; wa_a = 9; wd_a = 32'h00000123;
    tick();
    idle();
    #1;
    check_eq("iss_beats_wb", {31'b0, busy[0]}, 32'h1);
    tick();

    for (int r = 3; r <= 5; r++) begin
      iss_v = 1'b1; iss_rd = regaddr_t'(r);
      tick();
    end
    idle(); set_ra(0, 3); set_ra(1, 5);
    #1;
    check_eq("pre_flush", {30'b0, busy}, 32'h3);
    flush = 1'b1; iss_v = 1'b1; iss_rd = 6;
    tick();
    idle(); set_ra(0, 4); set_ra(1, 6);
    #1;
    check_eq("flush_clear", {30'b0, busy}, 32'h0);
    tick();

    for (int n = 0; n < 800; n++) begin
      rst    = ($urandom_range(0, 99) == 0);
      flush  = ($urandom_range(0, 29) == 0);
      iss_v  = ($urandom_range(0, 2) == 0);
      iss_rd = rnd_addr();
      we_a   = ($urandom_range(0, 1) == 0);
      wa_a   = rnd_addr();
      wd_a   = $urandom();
      we_b   = ($urandom_range(0, 2) == 0);
      wa_b   = ($urandom_range(0, 3) == 0) ? wa_a : rnd_addr();
      wd_b   = $urandom();
      for (int p = 0; p < NRD; p++) begin
        set_ra(p, ($urandom_range(0, 2) == 0) ? wa_a : rnd_addr());
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
